// File: rtl/com_cdc_hs_tx_if.sv
// Local valid/ready word interface for the CDC handshake transmitter.
//   ivld  : producer -> block, word valid
//   idata : producer -> block, word (DATA_W bits)
//   irdy  : block -> producer, block can take a word this cycle
// The producer must hold ivld/idata until irdy=1.
interface com_cdc_hs_tx_if #(
   parameter int DATA_W = 32
);
   logic              ivld;
   logic              irdy;
   logic [DATA_W-1:0] idata;

   modport master (output ivld, output idata, input irdy);
   modport slave  (input ivld, input idata, output irdy);
endinterface

// File: rtl/com_cdc_hs_tx.sv
// Source (transmit) end of a multi-bit clock-domain-crossing handshake.
// A word is taken on the local valid/ready interface and held on odata.
// The far domain is told about it by toggling oreq. The block then waits
// until the far end's toggle acknowledge, resynchronised through SYNC_S
// flops, matches oreq again. The far end samples odata only after its own
// synchronised copy of oreq has toggled, so odata is safe to cross.
//
// Ports
//   iclk   in   source-domain clock
//   irst   in   synchronous reset, active-high
//   bus    if   slave side of the valid/ready word interface (ivld, idata, irdy)
//   odata  out  held word to the far domain, changes only on accept
//   oreq   out  2-phase toggle request
//   iack   in   2-phase toggle acknowledge, asynchronous to iclk
//   obusy  out  transfer in flight
//   oerr   out  sticky acknowledge-timeout flag (0 when TO_CYC=0)
//   iclr   in   clears oerr
//
// State table
//   IDLE | ready for a word; irdy=1
//   WAIT | request outstanding; waiting for ack_s to match oreq
module com_cdc_hs_tx #(
   parameter int DATA_W = 32,
   parameter int SYNC_S = 2,
   parameter int TO_CYC = 0
) (
   input  logic              iclk,
   input  logic              irst,
   com_cdc_hs_tx_if.slave    bus,
   output logic [DATA_W-1:0] odata,
   output logic              oreq,
   input  logic              iack,
   output logic              obusy,
   output logic              oerr,
   input  logic              iclr
);

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] odata_q, odata_d;
   logic              oreq_q, oreq_d;
   (* ASYNC_REG = "TRUE" *) logic [SYNC_S-1:0] ack_sync_q;
   logic [SYNC_S-1:0] ack_sync_d;
   logic              ack_s;
   logic              accept;
   logic              ack_match;

   // Plain shift synchroniser; bit 0 is the metastable capture stage.
   always_comb begin
      ack_sync_d = {ack_sync_q[SYNC_S-2:0], iack};
   end

   assign ack_s = ack_sync_q[SYNC_S-1];

   always_comb begin
      state_d   = state_q;
      odata_d   = odata_q;
      oreq_d    = oreq_q;
      accept    = 1'b0;
      ack_match = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.ivld) begin
               accept  = 1'b1;
               odata_d = bus.idata;
               oreq_d  = ~oreq_q;
               state_d = WAIT;
            end
         end
         WAIT: begin
            // Request and acknowledge levels equal means the far end has seen
            // the latest toggle and answered it.
            if (ack_s == oreq_q) begin
               ack_match = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge iclk) begin
      if (irst) begin
         state_q    <= IDLE;
         odata_q    <= '0;
         oreq_q     <= 1'b0;
         ack_sync_q <= '0;
      end else begin
         state_q    <= state_d;
         odata_q    <= odata_d;
         oreq_q     <= oreq_d;
         ack_sync_q <= ack_sync_d;
      end
   end

   assign bus.irdy = (state_q == IDLE);
   assign obusy    = (state_q == WAIT);
   assign odata    = odata_q;
   assign oreq     = oreq_q;

   if (TO_CYC > 0) begin : g_to
      localparam int                CNT_W   = $clog2(TO_CYC + 1);
      localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TO_CYC);

      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             oerr_q, oerr_d;
      logic             to_hit;

      // The flag is raised only on the edge the counter arrives at TO_CYC,
      // so a clear while still waiting at saturation stays cleared.
      always_comb begin
         cnt_d  = cnt_q;
         to_hit = 1'b0;
         if (accept) begin
            cnt_d = '0;
         end else if ((state_q == WAIT) && !ack_match && (cnt_q != CNT_MAX)) begin
            cnt_d  = cnt_q + 1'b1;
            to_hit = (cnt_d == CNT_MAX);
         end
         oerr_d = oerr_q;
         if (iclr) begin
            oerr_d = 1'b0;
         end
         if (to_hit) begin
            oerr_d = 1'b1;
         end
      end

      always_ff @(posedge iclk) begin
         if (irst) begin
            cnt_q  <= '0;
            oerr_q <= 1'b0;
         end else begin
            cnt_q  <= cnt_d;
            oerr_q <= oerr_d;
         end
      end

      assign oerr = oerr_q;
   end else begin : g_no_to
      logic unused_to;
      assign unused_to = iclr ^ accept;
      assign oerr      = 1'b0;
   end

endmodule
